fir_sample_feeder: RTL and testbench
====================================

FIR_SAMPLE_FEEDER -- requirements
Module: fir_sample_feeder

Interface
REQ-001 Parameter INPUT_WIDTH, default 8: sample width, signed.
REQ-002 Parameter COEF_WIDTH, default 8: filter coefficient width; used only to size RESULT_WIDTH.
REQ-003 Parameter NUM_OF_TAPS, default 3: filter tap count; used only to size RESULT_WIDTH.
REQ-004 Parameter FIFO_DEPTH, default 4: input FIFO entries, power of two, >= 2.
REQ-005 Parameter RESULT_LAT, default 0: cycles from fir_done seen high to fir_result capture.
REQ-006 Parameter TIMEOUT, default 64: maximum wait cycles per wait state.
REQ-007 Localparam RESULT_WIDTH = INPUT_WIDTH+COEF_WIDTH+NUM_OF_TAPS-1.
REQ-008 Ports: one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-009 clk  input  1  rising-edge clock for all state.
REQ-010 rst_n  input  1  asynchronous active-low reset.
REQ-011 s_data  input  INPUT_WIDTH  upstream sample, signed.
REQ-012 s_valid  input  1  upstream sample valid.
REQ-013 s_ready  output  1  FIFO can accept a sample.
REQ-014 fir_data  output  INPUT_WIDTH  sample presented to the filter.
REQ-015 fir_start  output  1  one-cycle filter start pulse.
REQ-016 fir_done  input  1  filter idle/done flag (high = idle).
REQ-017 fir_result  input  RESULT_WIDTH  filter accumulator output, signed.
REQ-018 m_data  output  RESULT_WIDTH  captured result, signed.
REQ-019 m_valid  output  1  m_data valid.
REQ-020 m_ready  input  1  downstream accepts m_data.
REQ-021 fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-022 timeout_err  output  1  sticky error flag.

Function
REQ-023 s_ready SHALL equal (fifo_level < FIFO_DEPTH), combinational from registered level; push on s_valid && s_ready.
REQ-024 FIFO SHALL be first-in-first-out, pointers wrap modulo FIFO_DEPTH; no bypass (sample pushed in cycle n poppable no earlier than n+1); push and pop in same cycle leave level unchanged.
REQ-025 FSM states SHALL be IDLE, START, WAIT_LOW, WAIT_HIGH, SETTLE.
REQ-026 IDLE -> START when fifo_level > 0 and m_valid == 0: pop head into fir_data, register fir_start = 1; otherwise stay.
REQ-027 fir_start SHALL be high exactly during START (one cycle); START -> WAIT_LOW unconditionally.
REQ-028 fir_data SHALL stay stable from pop until the next pop.
REQ-029 WAIT_LOW -> WAIT_HIGH when fir_done == 0.
REQ-030 WAIT_HIGH on fir_done == 1: if RESULT_LAT == 0 capture fir_result into m_data, set m_valid, -> IDLE; else -> SETTLE.
REQ-031 SETTLE SHALL count RESULT_LAT cycles, then capture fir_result, set m_valid, -> IDLE.
REQ-032 Wait counter SHALL clear on entry to WAIT_LOW and WAIT_HIGH and increment each cycle there; reaching TIMEOUT without the exit condition SHALL set timeout_err, discard the sample (no m_valid), -> IDLE.
REQ-033 timeout_err SHALL be sticky; cleared only by reset.
REQ-034 m_valid SHALL hold with m_data stable until m_valid && m_ready; cleared that cycle.
REQ-035 New pop SHALL not occur while m_valid == 1; m_valid clearing and a pop SHALL not occur in the same cycle (pop earliest next cycle).
REQ-036 m_data SHALL be fir_result unmodified, full RESULT_WIDTH, no truncation or saturation.
REQ-037 s_valid while full SHALL be ignored; sample is not lost from upstream's view because s_ready is low.

Reset
REQ-038 While rst_n == 0: state IDLE, FIFO empty, fifo_level 0, s_ready 1 one cycle after release... reset value of s_ready SHALL be 1 (level 0).
REQ-039 Reset values: fir_data 0, fir_start 0, m_data 0, m_valid 0, timeout_err 0, wait counter 0.
REQ-040 Reset mid-operation SHALL abort any transaction immediately; queued samples and any pending result are lost.

Verification
REQ-041 Push 5 into empty FIFO at cycle n, responder drops done at n+3, raises at n+6 with result 42 -> fir_start high at n+2 only, fir_data 5, m_valid at n+7, m_data 42.
REQ-042 Push 4 samples back-to-back with m_ready low -> level 4, s_ready 0, fifth s_valid ignored; one result held in m_data, no further fir_start until m_ready.
REQ-043 Samples -3, 7, 1 with m_ready high, responder fixed 5-cycle done-low -> three fir_start pulses in order, fir_data -3, 7, 1; results appear in same order.
REQ-044 Responder never drops fir_done, TIMEOUT 64 -> timeout_err set 64 cycles after entering WAIT_LOW, no m_valid, next sample still started.
REQ-045 RESULT_LAT 2 -> capture 2 cycles after fir_done high; fir_result changes 1 cycle after done ignored, final value captured.
REQ-046 rst_n low during WAIT_HIGH with 2 queued samples -> all outputs at reset values, fifo_level 0, no fir_start after release until new push.

Source files
------------

// File: rtl/fir_sample_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : fir_sample_feeder
//  Description : Buffers upstream samples in a small FIFO and runs them one at
//                a time through an external FIR engine, holding each result
//                until downstream accepts it.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_sample_feeder #(
    parameter int INPUT_WIDTH = 8,
    parameter int COEF_WIDTH  = 8,
    parameter int NUM_OF_TAPS = 3,
    parameter int FIFO_DEPTH  = 4,
    parameter int RESULT_LAT  = 0,
    parameter int TIMEOUT     = 64,
    localparam int RESULT_WIDTH = INPUT_WIDTH + COEF_WIDTH + NUM_OF_TAPS - 1,
    localparam int LEVEL_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic signed [INPUT_WIDTH-1:0]  s_data,
    input  logic                           s_valid,
    output logic                           s_ready,
    output logic signed [INPUT_WIDTH-1:0]  fir_data,
    output logic                           fir_start,
    input  logic                           fir_done,
    input  logic signed [RESULT_WIDTH-1:0] fir_result,
    output logic signed [RESULT_WIDTH-1:0] m_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [LEVEL_WIDTH-1:0]         fifo_level,
    output logic                           timeout_err
);

    localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
    localparam int CNT_MAX   = (TIMEOUT > RESULT_LAT) ? TIMEOUT : RESULT_LAT;
    localparam int CNT_WIDTH = $clog2(CNT_MAX + 1);

    localparam logic [CNT_WIDTH-1:0]   c_timeout_last = CNT_WIDTH'(TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0]   c_settle_last  =
        CNT_WIDTH'((RESULT_LAT > 0) ? RESULT_LAT - 1 : 0);
    localparam logic [LEVEL_WIDTH-1:0] c_depth        = LEVEL_WIDTH'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_LOW  = 3'd2,
        S_WAIT_HIGH = 3'd3,
        S_SETTLE    = 3'd4
    } state_t;

    state_t                        r_state;
    logic [CNT_WIDTH-1:0]          r_cnt;
    logic signed [INPUT_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]          r_wr_ptr;
    logic [PTR_WIDTH-1:0]          r_rd_ptr;
    logic [LEVEL_WIDTH-1:0]        r_level;
    logic                          w_push;
    logic                          w_pop;

    assign fifo_level = r_level;
    assign s_ready    = (r_level < c_depth);
    assign w_push     = s_valid && s_ready;
    // Registered level and m_valid gate the pop: no bypass, and no pop in the
    // cycle a held result is handed off.
    assign w_pop      = (r_state == S_IDLE) && (r_level != '0) && !m_valid;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            fir_data    <= '0;
            fir_start   <= 1'b0;
            m_data      <= '0;
            m_valid     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            fir_start <= 1'b0;
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        fir_data  <= r_mem[r_rd_ptr];
                        fir_start <= 1'b1;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT_LOW;
                end
                S_WAIT_LOW: begin
                    if (!fir_done) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT_HIGH;
                    end else if (r_cnt == c_timeout_last) begin
                        timeout_err <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    if (fir_done) begin
                        r_cnt <= '0;
                        if (RESULT_LAT == 0) begin
                            m_data  <= fir_result;
                            m_valid <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_SETTLE;
                        end
                    end else if (r_cnt == c_timeout_last) begin
                        timeout_err <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SETTLE: begin
                    // The engine output may still be moving; sample only on the last settle cycle.
                    if (r_cnt == c_settle_last) begin
                        m_data  <= fir_result;
                        m_valid <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_sample_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_sample_feeder
//  Description : Self-checking bench for fir_sample_feeder with a scripted FIR
//                responder and a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fir_sample_feeder;

    localparam int IW    = 8;
    localparam int RW    = 18;
    localparam int DEPTH = 4;
    localparam int LW    = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b0;

    logic signed [IW-1:0] s_data = '0;
    logic                 s_valid = 1'b0;
    logic                 s_ready;
    logic signed [IW-1:0] fir_data;
    logic                 fir_start;
    logic                 fir_done = 1'b1;
    logic signed [RW-1:0] fir_result = '0;
    logic signed [RW-1:0] m_data;
    logic                 m_valid;
    logic                 m_ready = 1'b0;
    logic [LW-1:0]        fifo_level;
    logic                 timeout_err;

    logic signed [IW-1:0] s_data_b = '0;
    logic                 s_valid_b = 1'b0;
    logic                 s_ready_b;
    logic signed [IW-1:0] fir_data_b;
    logic                 fir_start_b;
    logic                 fir_done_b = 1'b1;
    logic signed [RW-1:0] fir_result_b = '0;
    logic signed [RW-1:0] m_data_b;
    logic                 m_valid_b;
    logic                 m_ready_b = 1'b0;
    logic [LW-1:0]        fifo_level_b;
    logic                 timeout_err_b;

    fir_sample_feeder #(
        .INPUT_WIDTH(IW), .COEF_WIDTH(8), .NUM_OF_TAPS(3),
        .FIFO_DEPTH(DEPTH), .RESULT_LAT(0), .TIMEOUT(64)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .fir_data(fir_data), .fir_start(fir_start),
        .fir_done(fir_done), .fir_result(fir_result),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .fifo_level(fifo_level), .timeout_err(timeout_err)
    );

    fir_sample_feeder #(
        .INPUT_WIDTH(IW), .COEF_WIDTH(8), .NUM_OF_TAPS(3),
        .FIFO_DEPTH(DEPTH), .RESULT_LAT(2), .TIMEOUT(64)
    ) dut_lat (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data_b), .s_valid(s_valid_b), .s_ready(s_ready_b),
        .fir_data(fir_data_b), .fir_start(fir_start_b),
        .fir_done(fir_done_b), .fir_result(fir_result_b),
        .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready_b),
        .fifo_level(fifo_level_b), .timeout_err(timeout_err_b)
    );

    int checks = 0;
    int errors = 0;

    // Responder for the main instance: after each start, wait rsp_pre cycles,
    // hold done low for rsp_low cycles, then raise done with a result.
    int                   rsp_pre = 0;
    int                   rsp_low = 1;
    bit                   rsp_hang = 0;
    bit                   rsp_rand = 0;
    bit                   rsp_fix = 0;
    logic signed [RW-1:0] rsp_val = '0;
    logic signed [RW-1:0] exp_res[$];
    int                   rsp_phase = 0;
    int                   rsp_cnt = 0;

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            rsp_phase = 0;
            fir_done  = 1'b1;
        end else begin
            case (rsp_phase)
                0: if (fir_start && !rsp_hang) begin
                    rsp_cnt   = rsp_rand ? int'($urandom_range(0, 4)) : rsp_pre;
                    rsp_phase = 1;
                end
                1: if (rsp_cnt == 0) begin
                    fir_done  = 1'b0;
                    rsp_cnt   = rsp_rand ? int'($urandom_range(1, 8)) : rsp_low;
                    rsp_phase = 2;
                end else begin
                    rsp_cnt--;
                end
                default: begin
                    rsp_cnt--;
                    if (rsp_cnt == 0) begin
                        fir_done   = 1'b1;
                        fir_result = rsp_fix ? rsp_val : RW'($urandom);
                        exp_res.push_back(fir_result);
                        rsp_phase  = 0;
                    end
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
        checks++; if (fir_start !== 1'b0) begin errors++; $display("FAIL reset_fir_start: got %b want 0", fir_start); end
        checks++; if (fir_data !== '0) begin errors++; $display("FAIL reset_fir_data: got %0d want 0", fir_data); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        checks++; if (m_data !== '0) begin errors++; $display("FAIL reset_m_data: got %0d want 0", m_data); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
        rst_n = 1'b1;
        tick();
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_release_s_ready: got %b want 1", s_ready); end
    endtask

    task automatic test_single();
        logic exp_fs;
        logic exp_mv;
        exp_res.delete();
        rsp_hang = 0; rsp_rand = 0; rsp_fix = 1; rsp_val = 18'sd42;
        rsp_pre = 0; rsp_low = 3; m_ready = 1'b0;
        s_valid = 1'b1; s_data = 8'sd5;
        for (int c = 1; c <= 8; c++) begin
            tick();
            s_valid = 1'b0;
            exp_fs = (c == 2);
            exp_mv = (c >= 7);
            checks++; if (fir_start !== exp_fs) begin errors++; $display("FAIL single_fir_start c+%0d: got %b want %b", c, fir_start, exp_fs); end
            checks++; if (m_valid !== exp_mv) begin errors++; $display("FAIL single_m_valid c+%0d: got %b want %b", c, m_valid, exp_mv); end
            if (c == 2) begin
                checks++; if (fir_data !== 8'sd5) begin errors++; $display("FAIL single_fir_data: got %0d want 5", fir_data); end
            end
        end
        checks++; if (m_data !== 18'sd42) begin errors++; $display("FAIL single_m_data: got %0d want 42", m_data); end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_m_valid_clear: got %b want 0", m_valid); end
        rsp_fix = 0;
        exp_res.delete();
    endtask

    task automatic test_full();
        logic signed [IW-1:0] smp[6];
        logic signed [RW-1:0] r0;
        logic signed [IW-1:0] got[$];
        logic signed [RW-1:0] res_got[$];
        int n;
        int starts;
        exp_res.delete();
        rsp_pre = 0; rsp_low = 2; m_ready = 1'b0;
        for (int i = 0; i < 6; i++) smp[i] = IW'($urandom);
        s_valid = 1'b1; s_data = smp[0];
        tick();
        s_valid = 1'b0;
        n = 0;
        while (!m_valid && n < 30) begin tick(); n++; end
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL full_first_result: got m_valid %b want 1", m_valid); end
        r0 = (exp_res.size() > 0) ? exp_res.pop_front() : '0;
        checks++; if (m_data !== r0) begin errors++; $display("FAIL full_first_m_data: got %0d want %0d", m_data, r0); end
        for (int i = 1; i <= 5; i++) begin
            s_valid = 1'b1; s_data = smp[i];
            tick();
        end
        s_valid = 1'b0;
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL full_level: got %0d want 4", fifo_level); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL full_s_ready: got %b want 0", s_ready); end
        starts = 0;
        repeat (10) begin tick(); if (fir_start) starts++; end
        checks++; if (starts != 0) begin errors++; $display("FAIL full_no_start_while_held: got %0d starts want 0", starts); end
        checks++; if (m_valid !== 1'b1 || m_data !== r0) begin errors++; $display("FAIL full_result_held: got %b/%0d want 1/%0d", m_valid, m_data, r0); end
        m_ready = 1'b1;
        tick();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL full_handoff_clear: got %b want 0", m_valid); end
        checks++; if (fir_start !== 1'b0) begin errors++; $display("FAIL full_pop_same_cycle: got fir_start %b want 0", fir_start); end
        for (int c = 0; c < 120; c++) begin
            if (fir_start) got.push_back(fir_data);
            if (m_valid && m_ready) res_got.push_back(m_data);
            tick();
        end
        checks++; if (got.size() != 4) begin errors++; $display("FAIL full_start_count: got %0d want 4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            checks++; if (got[i] !== smp[i+1]) begin errors++; $display("FAIL full_order[%0d]: got %0d want %0d", i, got[i], smp[i+1]); end
        end
        checks++; if (res_got.size() != exp_res.size()) begin errors++; $display("FAIL full_result_count: got %0d want %0d", res_got.size(), exp_res.size()); end
        for (int i = 0; i < res_got.size() && i < exp_res.size(); i++) begin
            checks++; if (res_got[i] !== exp_res[i]) begin errors++; $display("FAIL full_result[%0d]: got %0d want %0d", i, res_got[i], exp_res[i]); end
        end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL full_drained_level: got %0d want 0", fifo_level); end
        m_ready = 1'b0;
        exp_res.delete();
    endtask

    task automatic test_order();
        logic signed [IW-1:0] vals[3];
        logic signed [IW-1:0] got[$];
        logic signed [RW-1:0] res_got[$];
        vals[0] = -8'sd3; vals[1] = 8'sd7; vals[2] = 8'sd1;
        exp_res.delete();
        rsp_pre = 0; rsp_low = 5; m_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            s_valid = (c < 3);
            if (c < 3) s_data = vals[c];
            if (fir_start) got.push_back(fir_data);
            if (m_valid && m_ready) res_got.push_back(m_data);
            tick();
        end
        s_valid = 1'b0;
        checks++; if (got.size() != 3) begin errors++; $display("FAIL order_start_count: got %0d want 3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            checks++; if (got[i] !== vals[i]) begin errors++; $display("FAIL order_fir_data[%0d]: got %0d want %0d", i, got[i], vals[i]); end
        end
        checks++; if (res_got.size() != 3 || exp_res.size() != 3) begin errors++; $display("FAIL order_result_count: got %0d want 3", res_got.size()); end
        for (int i = 0; i < res_got.size() && i < exp_res.size(); i++) begin
            checks++; if (res_got[i] !== exp_res[i]) begin errors++; $display("FAIL order_result[%0d]: got %0d want %0d", i, res_got[i], exp_res[i]); end
        end
        exp_res.delete();
    endtask

    task automatic test_timeout();
        logic signed [IW-1:0] a;
        logic signed [IW-1:0] b;
        int  n;
        bit  mv_seen;
        exp_res.delete();
        a = IW'($urandom); b = IW'($urandom);
        rsp_hang = 1; rsp_pre = 0; rsp_low = 2; m_ready = 1'b1;
        s_valid = 1'b1; s_data = a; tick();
        s_data = b; tick();
        s_valid = 1'b0;
        n = 0;
        while (!fir_start && n < 20) begin tick(); n++; end
        checks++; if (fir_start !== 1'b1 || fir_data !== a) begin errors++; $display("FAIL timeout_first_start: got %b/%0d want 1/%0d", fir_start, fir_data, a); end
        mv_seen = 0;
        for (int k = 1; k <= 66; k++) begin
            tick();
            if (m_valid) mv_seen = 1;
            if (k == 64) begin
                checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b want 0 at +64", timeout_err); end
            end
            if (k == 65) begin
                checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_set: got %b want 1 at +65", timeout_err); end
                rsp_hang = 0;
            end
            if (k == 66) begin
                checks++; if (fir_start !== 1'b1 || fir_data !== b) begin errors++; $display("FAIL timeout_next_start: got %b/%0d want 1/%0d", fir_start, fir_data, b); end
            end
        end
        checks++; if (mv_seen) begin errors++; $display("FAIL timeout_discard: got m_valid 1 want 0"); end
        n = 0;
        while (!m_valid && n < 30) begin tick(); n++; end
        checks++; if (m_valid !== 1'b1 || exp_res.size() != 1 || m_data !== exp_res[0]) begin errors++; $display("FAIL timeout_next_result: got %b/%0d want 1 and one expected", m_valid, m_data); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b want 1", timeout_err); end
        tick();
        m_ready = 1'b0;
        exp_res.delete();
    endtask

    task automatic test_result_lat();
        logic signed [IW-1:0] v;
        logic signed [RW-1:0] r1;
        logic signed [RW-1:0] r2;
        int n;
        v = IW'($urandom); r1 = RW'($urandom); r2 = ~r1;
        s_valid_b = 1'b1; s_data_b = v; tick();
        s_valid_b = 1'b0;
        n = 0;
        while (!fir_start_b && n < 20) begin tick(); n++; end
        checks++; if (fir_start_b !== 1'b1 || fir_data_b !== v) begin errors++; $display("FAIL lat_start: got %b/%0d want 1/%0d", fir_start_b, fir_data_b, v); end
        tick(); fir_done_b = 1'b0;
        tick();
        tick(); fir_done_b = 1'b1; fir_result_b = r1;
        tick(); fir_result_b = r2;
        checks++; if (m_valid_b !== 1'b0) begin errors++; $display("FAIL lat_early_d1: got %b want 0", m_valid_b); end
        tick();
        checks++; if (m_valid_b !== 1'b0) begin errors++; $display("FAIL lat_early_d2: got %b want 0", m_valid_b); end
        tick(); fir_result_b = r1;
        checks++; if (m_valid_b !== 1'b1) begin errors++; $display("FAIL lat_m_valid: got %b want 1", m_valid_b); end
        checks++; if (m_data_b !== r2) begin errors++; $display("FAIL lat_m_data: got %0d want %0d", m_data_b, r2); end
        tick();
        checks++; if (m_data_b !== r2) begin errors++; $display("FAIL lat_m_data_stable: got %0d want %0d", m_data_b, r2); end
        m_ready_b = 1'b1; tick(); m_ready_b = 1'b0;
        checks++; if (m_valid_b !== 1'b0) begin errors++; $display("FAIL lat_clear: got %b want 0", m_valid_b); end
    endtask

    task automatic test_reset_mid();
        int starts;
        int mvs;
        int n;
        exp_res.delete();
        rsp_pre = 0; rsp_low = 10; m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = IW'($urandom); tick();
        end
        s_valid = 1'b0;
        repeat (3) tick();
        checks++; if (fifo_level !== 3'd2) begin errors++; $display("FAIL rmid_queued: got %0d want 2", fifo_level); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (fifo_level !== 3'd0 || s_ready !== 1'b1) begin errors++; $display("FAIL rmid_fifo: got %0d/%b want 0/1", fifo_level, s_ready); end
        checks++; if (fir_data !== '0 || fir_start !== 1'b0) begin errors++; $display("FAIL rmid_fir: got %0d/%b want 0/0", fir_data, fir_start); end
        checks++; if (m_data !== '0 || m_valid !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL rmid_outputs: got %0d/%b/%b want 0/0/0", m_data, m_valid, timeout_err); end
        tick(); tick();
        rst_n = 1'b1;
        starts = 0; mvs = 0;
        repeat (20) begin tick(); if (fir_start) starts++; if (m_valid) mvs++; end
        checks++; if (starts != 0 || mvs != 0) begin errors++; $display("FAIL rmid_quiet: got %0d starts %0d valids want 0", starts, mvs); end
        s_valid = 1'b1; s_data = 8'sd9; tick(); s_valid = 1'b0;
        n = 0;
        while (!fir_start && n < 20) begin tick(); n++; end
        checks++; if (fir_start !== 1'b1 || fir_data !== 8'sd9) begin errors++; $display("FAIL rmid_restart: got %b/%0d want 1/9", fir_start, fir_data); end
        repeat (20) tick();
        exp_res.delete();
    endtask

    task automatic test_random_stream();
        logic signed [IW-1:0] smp_q[$];
        logic signed [IW-1:0] exp_d;
        logic signed [RW-1:0] exp_r;
        logic signed [RW-1:0] prev_md;
        bit prev_hold;
        int pushes;
        int starts;
        int exp_lvl;
        exp_res.delete();
        rsp_rand = 1; rsp_fix = 0; rsp_hang = 0;
        pushes = 0; starts = 0; prev_hold = 0; prev_md = '0;
        for (int c = 0; c < 600; c++) begin
            if (fir_start) begin
                starts++;
                exp_d = (smp_q.size() > 0) ? smp_q.pop_front() : '0;
                checks++; if (fir_data !== exp_d) begin errors++; $display("FAIL rand_fir_data c%0d: got %0d want %0d", c, fir_data, exp_d); end
                checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rand_start_while_valid c%0d: got m_valid %b want 0", c, m_valid); end
            end
            exp_lvl = pushes - starts;
            checks++; if (int'(fifo_level) != exp_lvl) begin errors++; $display("FAIL rand_level c%0d: got %0d want %0d", c, fifo_level, exp_lvl); end
            checks++; if (s_ready !== (exp_lvl < DEPTH)) begin errors++; $display("FAIL rand_s_ready c%0d: got %b want %b", c, s_ready, exp_lvl < DEPTH); end
            if (prev_hold) begin
                checks++; if (m_valid !== 1'b1 || m_data !== prev_md) begin errors++; $display("FAIL rand_hold c%0d: got %b/%0d want 1/%0d", c, m_valid, m_data, prev_md); end
            end
            s_valid = (c < 450) && ($urandom_range(0, 99) < 60);
            s_data  = IW'($urandom);
            m_ready = (c >= 450) || ($urandom_range(0, 1) == 1);
            if (s_valid && exp_lvl < DEPTH) begin
                smp_q.push_back(s_data);
                pushes++;
            end
            if (m_valid && m_ready) begin
                exp_r = (exp_res.size() > 0) ? exp_res.pop_front() : '0;
                checks++; if (m_data !== exp_r) begin errors++; $display("FAIL rand_m_data c%0d: got %0d want %0d", c, m_data, exp_r); end
            end
            prev_hold = m_valid && !m_ready;
            prev_md   = m_data;
            tick();
        end
        s_valid = 1'b0;
        checks++; if (smp_q.size() != 0 || pushes != starts) begin errors++; $display("FAIL rand_drain_samples: got %0d left, %0d/%0d want 0", smp_q.size(), pushes, starts); end
        checks++; if (exp_res.size() != 0) begin errors++; $display("FAIL rand_drain_results: got %0d left want 0", exp_res.size()); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rand_timeout_err: got %b want 0", timeout_err); end
        rsp_rand = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_full();
        test_order();
        test_timeout();
        test_result_lat();
        test_reset_mid();
        test_random_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
